// File: rtl/quadrature_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Gray-order phase states, direction constants and transition classifier.
package quad_pkg;

   typedef enum logic [1:0] {
      Q_00 = 2'b00,
      Q_10 = 2'b10,
      Q_11 = 2'b11,
      Q_01 = 2'b01
   } quad_state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef struct packed {
      logic legal;
      logic up;
   } quad_dir_t;

   // legal = exactly one phase changed; up = next follows prev in UP order
   function automatic quad_dir_t quad_dir(
      input logic [1:0] prev,
      input logic [1:0] next
   );
      quad_dir_t  r;
      logic [1:0] fwd;
      unique case (prev)
         Q_00:    fwd = Q_10;
         Q_10:    fwd = Q_11;
         Q_11:    fwd = Q_01;
         default: fwd = Q_00;
      endcase
      r.legal = ^(prev ^ next);
      r.up    = (next == fwd) ? DIR_UP : DIR_DN;
      return r;
   endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder pins, clear strobe and decoded outputs.
// master drives pins/clear, slave is the decoder.
interface quadrature_decoder_if #(
   parameter int WIDTH = 8
);

   logic             enc_a;
   logic             enc_b;
   logic             clear;
   logic [WIDTH-1:0] pos_count;
   logic             step;
   logic             dir;
   logic             err;

   modport master (
      output enc_a,
      output enc_b,
      output clear,
      input  pos_count,
      input  step,
      input  dir,
      input  err
   );

   modport slave (
      input  enc_a,
      input  enc_b,
      input  clear,
      output pos_count,
      output step,
      output dir,
      output err
   );

endinterface

// File: rtl/quad_input_filter.sv
// Synchroniser plus stability filter for the 2-bit A/B bus.
// accept is combinational and coincides with the edge that loads filt.
module quad_input_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] raw,
   input  logic       loaded,
   output logic [1:0] filt,
   output logic [1:0] value,
   output logic       accept
);

   localparam int CW =
      (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

   logic [SYNC_STAGES-1:0][1:0] sync;
   logic [1:0]                  s;
   logic [1:0]                  s_d1;
   logic [CW-1:0]               cnt;
   logic                        stable;
   logic                        pending;

   assign s      = sync[SYNC_STAGES-1];
   assign value  = s;
   assign stable = (s == s_d1);

   // before the first load any stable value must be taken
   assign pending = (s != filt) || !loaded;

   assign accept = stable && pending &&
                   (cnt == CW'(FILTER_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_d1 <= '0;
         filt <= '0;
         cnt  <= '0;
      end else begin
         s_d1 <= s;
         if (!stable) begin
            cnt <= '0;
         end else if (accept) begin
            filt <= s;
            cnt  <= '0;
         end else if (pending) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered x4 step/dir events and
// a wrapping position counter with synchronous clear.
module quadrature_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input logic                clk,
   input logic                reset,
   quadrature_decoder_if.slave bus
);

   logic [1:0]       filt;
   logic [1:0]       value;
   logic             accept;
   logic             valid;
   logic             step_d;
   logic             err_d;
   logic [WIDTH-1:0] count;
   logic             step_q;
   logic             dir_q;
   logic             err_q;
   quad_dir_t        qd;

   quad_input_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk    (clk),
      .reset  (reset),
      .raw    ({bus.enc_a, bus.enc_b}),
      .loaded (valid),
      .filt   (filt),
      .value  (value),
      .accept (accept)
   );

   assign qd = quad_dir(filt, value);

   // the first accepted value only seeds filt, no event
   always_comb begin
      step_d = 1'b0;
      err_d  = 1'b0;
      if (accept && valid) begin
         if (qd.legal) begin
            step_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid  <= 1'b0;
         count  <= '0;
         step_q <= 1'b0;
         dir_q  <= DIR_DN;
         err_q  <= 1'b0;
      end else begin
         step_q <= step_d;
         err_q  <= err_d;
         if (accept) begin
            valid <= 1'b1;
         end
         if (step_d) begin
            dir_q <= qd.up;
         end
         if (bus.clear) begin
            count <= '0;
         end else if (step_d) begin
            count <= qd.up ? count + 1'b1 : count - 1'b1;
         end
      end
   end

   assign bus.pos_count = count;
   assign bus.step      = step_q;
   assign bus.dir       = dir_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed vector table, hand
// sequences for clear/reset corners, random walk vs reference model.
module tb_quadrature_decoder;

   localparam int FC = 4;

   typedef struct {
      bit         rst;
      logic [1:0] ab;
      logic       clr;
      int         hold;
      int         steps;
      int         errs;
      int         lat;
      int         count;
      logic       dir;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   quadrature_decoder_if #(.WIDTH(8)) bus ();

   quadrature_decoder #(
      .WIDTH         (8),
      .SYNC_STAGES   (2),
      .FILTER_CYCLES (FC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference model: pin history and decoded state
   logic [2:0] h[$];
   bit         m_valid;
   logic [1:0] m_filt;
   int         m_cnt;
   bit         m_dir;
   bit         m_step;
   bit         m_err;

   vec_t tab[$];

   function automatic int gidx(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      h = {};
      for (int i = 0; i < FC + 3; i++)
         h.push_back((i >= FC) ? 3'b000 : 3'b100);
      m_valid = 0;
      m_filt  = 2'b00;
      m_cnt   = 0;
      m_dir   = 0;
      m_step  = 0;
      m_err   = 0;
   endtask

   // accept when the value seen two edges ago was held for FC+1 samples
   task automatic model_edge(input logic [1:0] ab, input logic clr);
      logic [2:0] w;
      bit         run;
      int         d;
      h.push_back({1'b0, ab});
      void'(h.pop_front());
      m_step = 0;
      m_err  = 0;
      w   = h[h.size() - 3];
      run = 1;
      for (int k = 1; k <= FC; k++)
         if (h[h.size() - 3 - k] != w) run = 0;
      if (run && (!m_valid || w[1:0] != m_filt)) begin
         if (m_valid) begin
            d = (gidx(w[1:0]) - gidx(m_filt)) & 3;
            if (d == 1) begin
               m_step = 1;
               m_dir  = 1;
               m_cnt  = (m_cnt + 1) % 256;
            end else if (d == 3) begin
               m_step = 1;
               m_dir  = 0;
               m_cnt  = (m_cnt + 255) % 256;
            end else begin
               m_err = 1;
            end
         end
         m_valid = 1;
         m_filt  = w[1:0];
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic cycle(input logic [1:0] ab, input logic clr);
      bus.enc_a = ab[1];
      bus.enc_b = ab[0];
      bus.clear = clr;
      @(posedge clk);
      model_edge(ab, clr);
      #1;
      check("step", bus.step, m_step);
      check("err", bus.err, m_err);
      check("dir", bus.dir, m_dir);
      check("pos_count", bus.pos_count, m_cnt);
      if (bus.step && bus.err) check("step_and_err", 1, 0);
   endtask

   task automatic do_reset(input logic [1:0] ab);
      bus.enc_a = ab[1];
      bus.enc_b = ab[0];
      bus.clear = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_pos_count", bus.pos_count, 0);
      check("rst_step", bus.step, 0);
      check("rst_dir", bus.dir, 0);
      check("rst_err", bus.err, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int nst;
      int ner;
      int lat;
      string tag;
      nst = 0;
      ner = 0;
      lat = 0;
      if (v.rst) do_reset(v.ab);
      for (int i = 1; i <= v.hold; i++) begin
         cycle(v.ab, v.clr);
         if ((bus.step || bus.err) && lat == 0) lat = i;
         nst += int'(bus.step);
         ner += int'(bus.err);
      end
      tag = $sformatf("vec%0d", idx);
      check({tag, "_steps"}, nst, v.steps);
      check({tag, "_errs"}, ner, v.errs);
      check({tag, "_latency"}, lat, v.lat);
      check({tag, "_count"}, bus.pos_count, v.count);
      check({tag, "_dir"}, bus.dir, v.dir);
   endtask

   initial begin
      logic [1:0] cur;
      logic [1:0] nxt;
      int         r;
      int         hold;

      bus.enc_a = 1'b0;
      bus.enc_b = 1'b0;
      bus.clear = 1'b0;
      model_reset();

      // rst ab clr hold steps errs lat count dir
      tab.push_back('{1, 2'b11, 0, 20, 0, 0, 0, 0,   0});
      tab.push_back('{1, 2'b00, 0, 10, 0, 0, 0, 0,   0});
      tab.push_back('{0, 2'b10, 0, 10, 1, 0, 7, 1,   1});
      tab.push_back('{0, 2'b11, 0, 10, 1, 0, 7, 2,   1});
      tab.push_back('{0, 2'b01, 0, 10, 1, 0, 7, 3,   1});
      tab.push_back('{0, 2'b00, 0, 10, 1, 0, 7, 4,   1});
      tab.push_back('{0, 2'b00, 1, 1,  0, 0, 0, 0,   1});
      tab.push_back('{0, 2'b01, 0, 10, 1, 0, 7, 255, 0});
      tab.push_back('{0, 2'b00, 0, 10, 1, 0, 7, 0,   1});
      tab.push_back('{0, 2'b10, 0, 3,  0, 0, 0, 0,   1});
      tab.push_back('{0, 2'b00, 0, 15, 0, 0, 0, 0,   1});
      tab.push_back('{0, 2'b11, 0, 10, 0, 1, 7, 0,   1});
      tab.push_back('{0, 2'b01, 0, 10, 1, 0, 7, 1,   1});
      tab.push_back('{0, 2'b00, 0, 10, 1, 0, 7, 2,   1});
      tab.push_back('{0, 2'b10, 0, 10, 1, 0, 7, 3,   1});
      tab.push_back('{0, 2'b11, 0, 10, 1, 0, 7, 4,   1});
      tab.push_back('{0, 2'b01, 0, 10, 1, 0, 7, 5,   1});

      foreach (tab[i]) run_vec(tab[i], i);

      // clear lands on the step cycle of an UP move at count 5
      for (int i = 0; i < 6; i++) cycle(2'b00, 1'b0);
      cycle(2'b00, 1'b1);
      check("clr_step", bus.step, 1);
      check("clr_dir", bus.dir, 1);
      check("clr_count", bus.pos_count, 0);
      cycle(2'b00, 1'b0);
      check("clr_after_count", bus.pos_count, 0);

      // move to count 1, then reset in the middle of filtering
      for (int i = 0; i < 10; i++) cycle(2'b10, 1'b0);
      check("pre_rst_count", bus.pos_count, 1);
      for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0);
      do_reset(2'b11);
      for (int i = 0; i < 12; i++) cycle(2'b11, 1'b0);
      check("reload_count", bus.pos_count, 0);

      // reset while step is high
      for (int i = 0; i < 7; i++) cycle(2'b01, 1'b0);
      check("mid_step", bus.step, 1);
      do_reset(2'b01);
      for (int i = 0; i < 10; i++) cycle(2'b01, 1'b0);

      // random walk: legal moves, double flips, short glitches
      cur = 2'b01;
      for (int s = 0; s < 80; s++) begin
         r = $urandom_range(0, 9);
         if (r < 6)
            nxt = cur ^ (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
         else if (r < 7)
            nxt = cur ^ 2'b11;
         else
            nxt = cur;
         hold = $urandom_range(1, 12);
         for (int i = 0; i < hold; i++)
            cycle(nxt, ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
         cur = nxt;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
